// File: rtl/hamming_uart_rx.sv
// hamming_uart_rx
//   UART receiver merged with a Hamming(7,4) / extended Hamming(8,4) decoder.
//   Each received codeword is decoded and corrected in a registered stage,
//   then queued in a small FIFO that the consumer drains with valid/ready.
//
// Ports
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   rx              : asynchronous serial input, idle high
//   out_valid       : FIFO head holds an entry
//   out_ready       : consumer accepts the head entry
//   out_data        : corrected data nibble {d4,d3,d2,d1}
//   out_syndrome    : {s4,s2,s1}
//   out_corrected   : single-bit error corrected
//   out_uncorr      : double error detected (SECDED only)
//   out_frame_err   : stop bit sampled low
//   overflow        : one-cycle pulse when a decoded frame is dropped
//   state_out       : receiver state for debug
//
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the head entry
// and all out_* fields hold steady. out_valid never depends on out_ready.
module hamming_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SECDED       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [2:0] out_syndrome,
  output logic       out_corrected,
  output logic       out_uncorr,
  output logic       out_frame_err,
  output logic       overflow,
  output logic [2:0] state_out
);
  localparam int N    = (SECDED != 0) ? 8 : 7;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t         r_state, w_next;
  logic           r_rx_meta, r_rx_s, r_rx_d;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_bit;
  logic [N-1:0]   r_shift;
  logic           r_pend_valid;
  logic [9:0]     r_pend;
  logic           w_cnt_clr, w_shift_en, w_stop_smp, w_frame_err;

  // ---------------- receiver FSM: next state ----------------
  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rx_d && !r_rx_s) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          w_cnt_clr = 1'b1;
          w_next    = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == 4'(N - 1)) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_clr   = 1'b1;
          w_stop_smp  = 1'b1;
          w_frame_err = !r_rx_s;
          w_next      = r_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- decoder (combinational on the full shift register) ----------------
  // Codeword position p lives at index p-1: p1 p2 d1 p4 d2 d3 d4 (+P).
  logic [6:0] w_c, w_flip, w_fix;
  logic [2:0] w_syn, w_syn_out;
  logic       w_par, w_corr, w_uncorr;
  logic [3:0] w_data;

  assign w_c   = r_shift[6:0];
  assign w_syn = {w_c[3] ^ w_c[4] ^ w_c[5] ^ w_c[6],
                  w_c[1] ^ w_c[2] ^ w_c[5] ^ w_c[6],
                  w_c[0] ^ w_c[2] ^ w_c[4] ^ w_c[6]};
  assign w_par  = ^r_shift;
  // Only meaningful when the syndrome is non-zero.
  assign w_flip = 7'(1) << (w_syn - 3'd1);

  always_comb begin
    w_fix     = w_c;
    w_corr    = 1'b0;
    w_uncorr  = 1'b0;
    w_syn_out = w_syn;
    if (SECDED == 0) begin
      if (w_syn != 3'd0) begin
        w_fix  = w_c ^ w_flip;
        w_corr = 1'b1;
      end
    end else if (w_par) begin
      // Odd overall parity: a single error, either in positions 1..7 or in P.
      w_corr = 1'b1;
      if (w_syn != 3'd0) w_fix = w_c ^ w_flip;
    end else if (w_syn != 3'd0) begin
      w_uncorr = 1'b1;
    end
  end

  assign w_data = {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};

  // ---------------- receiver datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_rx_d       <= 1'b1;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_s       <= r_rx_meta;
      r_rx_d       <= r_rx_s;
      r_state      <= w_next;
      r_cnt        <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (r_state == S_IDLE)  r_bit <= '0;
      else if (w_shift_en)    r_bit <= r_bit + 4'd1;
      // LSB first: after N shifts frame bit k sits at index k.
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[N-1:1]};
      r_pend_valid <= w_stop_smp;
      if (w_stop_smp) r_pend <= {w_frame_err, w_uncorr, w_corr, w_syn_out, w_data};
    end
  end

  // ---------------- output FIFO ----------------
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;
  logic            w_push, w_pop, w_full, w_wr_en;
  logic [9:0]      w_head;

  assign w_push  = r_pend_valid;
  assign w_full  = (r_count == CNTW'(FIFO_DEPTH));
  assign w_pop   = out_valid && out_ready;
  // A pop frees the slot in the same edge, so full+pop still accepts the push.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_pend;
  end

  assign out_valid = (r_count != '0);
  // Fields read as zero whenever the queue is empty (including after reset).
  assign w_head    = out_valid ? r_mem[r_rd_ptr] : 10'd0;

  assign out_frame_err = w_head[9];
  assign out_uncorr    = w_head[8];
  assign out_corrected = w_head[7];
  assign out_syndrome  = w_head[6:4];
  assign out_data      = w_head[3:0];
  assign overflow      = r_overflow;
  assign state_out     = r_state;
endmodule

// File: tb/tb_hamming_uart_rx.sv
module tb_hamming_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic       rx7, rx8, ready7, ready8;
  logic       valid7, valid8, corr7, corr8, unc7, unc8, ferr7, ferr8, ovf7, ovf8;
  logic [3:0] data7, data8;
  logic [2:0] syn7, syn8, st7, st8;
  logic [9:0] ent7, ent8;
  assign ent7 = {ferr7, unc7, corr7, syn7, data7};
  assign ent8 = {ferr8, unc8, corr8, syn8, data8};

  hamming_uart_rx #(.CLKS_PER_BIT(CPB), .SECDED(0), .FIFO_DEPTH(DEPTH)) u_dut7 (
    .clk(clk), .rst(rst), .rx(rx7), .out_valid(valid7), .out_ready(ready7),
    .out_data(data7), .out_syndrome(syn7), .out_corrected(corr7), .out_uncorr(unc7),
    .out_frame_err(ferr7), .overflow(ovf7), .state_out(st7));

  hamming_uart_rx #(.CLKS_PER_BIT(CPB), .SECDED(1), .FIFO_DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .out_valid(valid8), .out_ready(ready8),
    .out_data(data8), .out_syndrome(syn8), .out_corrected(corr8), .out_uncorr(unc8),
    .out_frame_err(ferr8), .overflow(ovf8), .state_out(st8));

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q7[$];
  logic [9:0] exp_q8[$];
  int ovf7_cnt = 0, ovf8_cnt = 0, exp_ovf7 = 0;
  int last_rise7 = -1;
  int mode7 = 1, mode8 = 1;   // 0: ready low, 1: ready high, 2: random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference decode: the syndrome is the XOR of the positions of all set bits.
  function automatic logic [9:0] model(input logic [7:0] f, input int secded, input logic ferr);
    int syn = 0;
    int par = 0;
    logic [7:0] c;
    logic corr = 1'b0;
    logic unc  = 1'b0;
    c = f;
    for (int i = 1; i <= 7; i++) if (f[i-1]) syn ^= i;
    for (int i = 0; i < 7 + secded; i++) par ^= int'(f[i]);
    if (secded == 0) begin
      if (syn != 0) begin c[syn-1] = ~c[syn-1]; corr = 1'b1; end
    end else if (par != 0) begin
      corr = 1'b1;
      if (syn != 0) c[syn-1] = ~c[syn-1];
    end else if (syn != 0) begin
      unc = 1'b1;
    end
    return {ferr, unc, corr, 3'(syn), c[6], c[5], c[4], c[2]};
  endfunction

  // ---------------- ready drivers ----------------
  initial begin
    ready7 = 1'b0;
    ready8 = 1'b0;
    forever begin
      @(posedge clk); #1;
      ready7 = (mode7 == 2) ? 1'($urandom_range(0, 1)) : (mode7 == 1);
      ready8 = (mode8 == 2) ? 1'($urandom_range(0, 1)) : (mode8 == 1);
    end
  end

  // ---------------- output monitors ----------------
  logic       prev_valid7 = 1'b0, hold7 = 1'b0, hold8 = 1'b0;
  logic [9:0] prev_ent7, prev_ent8;
  always @(negedge clk) begin
    if (rst) begin
      hold7 = 1'b0;
      hold8 = 1'b0;
      prev_valid7 = 1'b0;
    end else begin
      if (hold7) begin
        check("stable_valid7", valid7, 1);
        check("stable_entry7", ent7, prev_ent7);
      end
      if (hold8) begin
        check("stable_valid8", valid8, 1);
        check("stable_entry8", ent8, prev_ent8);
      end
      if (valid7 && ready7) begin
        if (exp_q7.size() == 0) check("unexpected_pop7", 1, 0);
        else check("entry7", ent7, exp_q7.pop_front());
      end
      if (valid8 && ready8) begin
        if (exp_q8.size() == 0) check("unexpected_pop8", 1, 0);
        else check("entry8", ent8, exp_q8.pop_front());
      end
      if (valid7 && !prev_valid7) last_rise7 = cyc;
      prev_valid7 = valid7;
      hold7 = valid7 && !ready7;
      hold8 = valid8 && !ready8;
      prev_ent7 = ent7;
      prev_ent8 = ent8;
      if (ovf7) ovf7_cnt++;
      if (ovf8) ovf8_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx7 = v;
    else rx8 = v;
  endtask

  // Called just after a rising edge; leaves rx at the stop level.
  task automatic send_frame(input int which, input logic [7:0] bits, input int nbits,
                            input logic stop_v);
    set_rx(which, 1'b0);
    repeat (CPB) @(posedge clk);
    #1;
    for (int k = 0; k < nbits; k++) begin
      set_rx(which, bits[k]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    set_rx(which, stop_v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q7.size() != 0 || exp_q8.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q7.size() + exp_q8.size(), 0);
  endtask

  task automatic random_stream(input int which, input int count);
    logic [7:0] f;
    logic       stop_v;
    for (int i = 0; i < count; i++) begin
      f = 8'($urandom);
      if (which == 0) f[7] = 1'b0;
      stop_v = ($urandom_range(0, 5) != 0);
      if (which == 0) exp_q7.push_back(model(f, 0, !stop_v));
      else            exp_q8.push_back(model(f, 1, !stop_v));
      send_frame(which, f, (which == 0) ? 7 : 8, stop_v);
      if (!stop_v) begin
        set_rx(which, 1'b1);
        repeat (4) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 40000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rx7 = 1'b1;
    rx8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid7", valid7, 0);
    check("rst_entry7", ent7, 0);
    check("rst_ovf7", ovf7, 0);
    check("rst_state7", st7, 0);
    check("rst_valid8", valid8, 0);
    check("rst_entry8", ent8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_state8", st8, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Clean frame, with latency: pin edge +2 sync, +CPB/2 start, +8*CPB to stop, +2 to valid.
    begin
      int start_cyc;
      start_cyc = cyc;
      exp_q7.push_back(10'h00B);
      send_frame(0, 8'h55, 7, 1'b1);
      check("clean_latency", last_rise7 - start_cyc, 2 + CPB / 2 + 8 * CPB + 2);
    end
    wait_drain();

    // Single error at position 5.
    exp_q7.push_back(10'h0DB);
    send_frame(0, 8'h45, 7, 1'b1);
    wait_drain();

    // SECDED: double error, then overall-parity-only error.
    exp_q8.push_back(10'h13B);
    send_frame(1, 8'h56, 8, 1'b1);
    exp_q8.push_back(10'h08B);
    send_frame(1, 8'hD5, 8, 1'b1);
    wait_drain();

    // Framing error, then BREAK until rx rises.
    mode7 = 0;
    exp_q7.push_back(10'h20B);
    send_frame(0, 8'h55, 7, 1'b0);
    check("break_state", st7, 4);
    check("ferr_queued", valid7, 1);
    rx7 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("break_exit", st7, 0);
    mode7 = 1;
    wait_drain();

    // 3-cycle glitch: enters START, rejected at mid-bit, nothing pushed.
    rx7 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_start", st7, 1);
    rx7 = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("glitch_idle", st7, 0);
    check("glitch_no_push", valid7, 0);

    // Backpressure: five frames into a four-entry queue.
    mode7 = 0;
    for (int i = 0; i < 5; i++) begin
      if (exp_q7.size() < DEPTH) exp_q7.push_back((i % 2 == 0) ? 10'h00B : 10'h0DB);
      else exp_ovf7++;
      send_frame(0, (i % 2 == 0) ? 8'h55 : 8'h45, 7, 1'b1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("bp_overflow_pulses", ovf7_cnt, exp_ovf7);
    check("bp_valid_held", valid7, 1);
    mode7 = 1;
    wait_drain();
    check("bp_overflow_after_drain", ovf7_cnt, exp_ovf7);

    // Reset in the middle of DATA with two entries queued.
    mode7 = 0;
    exp_q7.push_back(10'h00B);
    send_frame(0, 8'h55, 7, 1'b1);
    exp_q7.push_back(10'h0DB);
    send_frame(0, 8'h45, 7, 1'b1);
    rx7 = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("pre_reset_state", st7, 2);
    check("pre_reset_valid", valid7, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx7 = 1'b1;
    exp_q7.delete();
    check("post_reset_state", st7, 0);
    check("post_reset_valid", valid7, 0);
    check("post_reset_entry", ent7, 0);
    repeat (3 * CPB) @(posedge clk);
    #1;
    mode7 = 1;
    exp_q7.push_back(10'h00B);
    send_frame(0, 8'h55, 7, 1'b1);
    wait_drain();

    // Randomized back-to-back frames with a randomly stalling consumer.
    mode7 = 2;
    mode8 = 2;
    fork
      random_stream(0, 12);
      random_stream(1, 12);
    join
    mode7 = 1;
    mode8 = 1;
    wait_drain();
    check("final_overflow7", ovf7_cnt, exp_ovf7);
    check("final_overflow8", ovf8_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
